traffic_phase_ctrl: RTL



---
 rtl/traffic_phase_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/traffic_phase_ctrl.sv
// Phase sequencer for a two-road intersection with a latched pedestrian crossing.
// Outputs are registered and depend on the state register only.
module traffic_phase_ctrl #(
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 10,
    parameter int YELLOW_CYC = 2,
    parameter int WALK_CYC   = 3,
    parameter int CNT_W      = 5
) (
    input  logic       c_clk,
    input  logic       c_rst,
    input  logic       c_TA,
    input  logic       c_TB,
    input  logic       c_ped,
    output logic [1:0] c_LA,
    output logic [1:0] c_LB,
    output logic       c_walk,
    output logic [2:0] c_phase
);
    // state | meaning
    // AG    | road A green, B red
    // AY    | road A yellow, B red
    // BG    | road B green, A red
    // BY    | road B yellow, A red
    // WALK  | both red, pedestrian walk lamp on
    typedef enum logic [2:0] {
        ST_AG   = 3'd0,
        ST_AY   = 3'd1,
        ST_BG   = 3'd2,
        ST_BY   = 3'd3,
        ST_WALK = 3'd4
    } state_t;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_ped_pend;
    logic             r_last_a;
    logic [1:0]       r_la;
    logic [1:0]       r_lb;
    logic             r_walk;

    state_t w_next;
    logic   w_ag_exit;
    logic   w_bg_exit;
    logic   w_ped_next;

    // Decisions use the registered ped_pend, so a request on the deciding edge only latches.
    assign w_ag_exit = (r_timer >= T_GMIN) &&
                       (r_ped_pend || (c_TB && !c_TA) || (c_TB && (r_timer == T_GMAX)));
    assign w_bg_exit = (r_timer >= T_GMIN) &&
                       (r_ped_pend || (c_TA && !c_TB) || (c_TA && (r_timer == T_GMAX)));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_AG:   if (w_ag_exit) w_next = ST_AY;
            ST_BG:   if (w_bg_exit) w_next = ST_BY;
            ST_AY:   if (r_timer == T_YEL) w_next = r_ped_pend ? ST_WALK : ST_BG;
            ST_BY:   if (r_timer == T_YEL) w_next = r_ped_pend ? ST_WALK : ST_AG;
            ST_WALK: if (r_timer == T_WALK) w_next = r_last_a ? ST_BG : ST_AG;
            default: w_next = ST_AG;
        endcase
    end

    always_comb begin
        w_ped_next = r_ped_pend;
        if (c_ped && (r_state != ST_WALK)) w_ped_next = 1'b1;
        if ((w_next == ST_WALK) && (r_state != ST_WALK)) w_ped_next = 1'b0;
    end

    always_ff @(posedge c_clk) begin
        if (c_rst) begin
            r_state    <= ST_AG;
            r_timer    <= '0;
            r_ped_pend <= 1'b0;
            r_last_a   <= 1'b1;
            r_la       <= L_GREEN;
            r_lb       <= L_RED;
            r_walk     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ped_pend <= w_ped_next;
            if (w_next != r_state)
                r_timer <= '0;
            else if (r_timer != {CNT_W{1'b1}})
                r_timer <= r_timer + 1'b1;
            if (r_state == ST_AY) r_last_a <= 1'b1;
            if (r_state == ST_BY) r_last_a <= 1'b0;
            // Lamp registers follow the next state so they line up with r_state.
            r_walk <= (w_next == ST_WALK);
            case (w_next)
                ST_AY:   begin r_la <= L_YELLOW; r_lb <= L_RED;    end
                ST_BG:   begin r_la <= L_RED;    r_lb <= L_GREEN;  end
                ST_BY:   begin r_la <= L_RED;    r_lb <= L_YELLOW; end
                ST_WALK: begin r_la <= L_RED;    r_lb <= L_RED;    end
                default: begin r_la <= L_GREEN;  r_lb <= L_RED;    end
            endcase
        end
    end

    assign c_LA    = r_la;
    assign c_LB    = r_lb;
    assign c_walk  = r_walk;
    assign c_phase = r_state;

endmodule
